// File: rtl/uart_msg_tx.sv
// uart_msg_tx: sends a message of len bytes read from a message memory as
// back-to-back 8N1 UART frames, then pulses done.
module uart_msg_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] sel,
  input  logic [5:0] len,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [5:0] MAX_LEN = 6'd32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START_BIT,
    DATA,
    STOP,
    NEXT,
    FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [5:0]        len_q, len_d;
  logic [4:0]        idx_q, idx_d;
  logic [2:0]        bit_q, bit_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        mem_addr_d;
  logic              tx_d, busy_d, done_d;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  // State, datapath and registered outputs; outputs are decoded from the
  // next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      bit_q    <= '0;
      baud_q   <= '0;
      shift_q  <= '0;
      mem_addr <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      bit_q    <= bit_d;
      baud_q   <= baud_d;
      shift_q  <= shift_d;
      mem_addr <= mem_addr_d;
      tx       <= tx_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next-state, datapath updates and next output values.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    len_d      = len_q;
    idx_d      = idx_q;
    bit_d      = bit_q;
    baud_d     = baud_q;
    shift_d    = shift_q;
    mem_addr_d = mem_addr;
    tx_d       = 1'b1;
    busy_d     = 1'b1;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d   = sel;
          len_d   = (len > MAX_LEN) ? MAX_LEN : len;
          idx_d   = '0;
          bit_d   = '0;
          baud_d  = '0;
          state_d = (len == 6'd0) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = mem_data;
        baud_d  = '0;
        state_d = START_BIT;
      end
      START_BIT: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = NEXT;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      NEXT: begin
        if (({1'b0, idx_q} + 6'd1) < len_q) begin
          idx_d   = idx_q + 5'd1;
          state_d = FETCH;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == FETCH) begin
      mem_addr_d = {sel_d, idx_d};
    end
    case (state_d)
      START_BIT: tx_d = 1'b0;
      DATA:      tx_d = shift_d[0];
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

endmodule

// File: tb/tb_uart_msg_tx.sv
// tb_uart_msg_tx: directed bench for uart_msg_tx with CLKS_PER_BIT=4, a
// synchronous message memory model and an independent UART line decoder.
module tb_uart_msg_tx;

  localparam int unsigned CPB = 4;
  localparam int BYTE_CYC = 10 * CPB + 3;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] sel;
  logic [5:0] len;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       tx;
  logic       busy;
  logic       done;

  logic [7:0] mem [256];

  int n_cmp;
  int n_fail;

  logic       trace[$];
  logic       btrace[$];
  logic [7:0] rx_bytes[$];
  int         fstart[$];
  logic [7:0] faddr[$];
  int         done_cnt;
  int         done_cyc;
  int         frame_err;
  logic       busy_after;

  uart_msg_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sel      (sel),
    .len      (len),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read message memory: data valid one cycle after address.
  always @(posedge clk) mem_data <= mem[mem_addr];

  // Runs max_cyc cycles after a start cycle set up by the caller, recording
  // the line and decoding frames; optional start pulse / reset at given cycles.
  task automatic run_msg(input int max_cyc, input int pulse_at, input int reset_at);
    int fpos;
    logic [7:0] sh;
    trace.delete(); btrace.delete(); rx_bytes.delete(); fstart.delete(); faddr.delete();
    done_cnt = 0; done_cyc = -1; frame_err = 0; busy_after = 1'bx;
    fpos = -1; sh = '0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      trace.push_back(tx);
      btrace.push_back(busy);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c == done_cyc + 1) busy_after = busy;
      if (fpos < 0) begin
        if (tx === 1'b0) begin
          fpos = 0;
          fstart.push_back(c);
          faddr.push_back(mem_addr);
        end
      end else begin
        fpos++;
      end
      if (fpos >= 0) begin
        if (fpos == 2 && tx !== 1'b0) frame_err++;
        if (fpos >= 6 && fpos <= 34 && (fpos % 4) == 2) sh[3'((fpos - 6) / 4)] = tx;
        if (fpos == 38 && tx !== 1'b1) frame_err++;
        if (fpos == 39) begin
          rx_bytes.push_back(sh);
          fpos = -1;
        end
      end
      if (c == 1) begin
        sel = sel ^ 3'b101;
        len = 6'd7;
      end
      start = (c == pulse_at);
      reset = (c == reset_at);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b1; sel = 3'd2; len = 6'd1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", mem_addr); end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_priority_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_byte();
    logic [9:0] frame;
    logic exp;
    frame = {1'b1, 8'hA5, 1'b0};
    mem[8'h40] = 8'hA5;
    sel = 3'd2; len = 6'd1; start = 1'b1;
    run_msg(50, -1, -1);
    n_cmp++; if (btrace[0] !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", btrace[0]); end
    n_cmp++; if (faddr.size() !== 1) begin n_fail++; $display("FAIL single_frames: got %0d expected 1", faddr.size()); end
    else begin
      n_cmp++; if (faddr[0] !== 8'h40) begin n_fail++; $display("FAIL single_addr: got %h expected 40", faddr[0]); end
    end
    for (int c = 1; c <= 50; c++) begin
      exp = (c >= 3 && c <= 42) ? frame[(c - 3) / 4] : 1'b1;
      n_cmp++; if (trace[c-1] !== exp) begin n_fail++; $display("FAIL single_tx_c%0d: got %b expected %b", c, trace[c-1], exp); end
    end
    n_cmp++; if (done_cyc !== BYTE_CYC + 1) begin n_fail++; $display("FAIL single_done_cyc: got %0d expected %0d", done_cyc, BYTE_CYC + 1); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL single_done_cnt: got %0d expected 1", done_cnt); end
    n_cmp++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b expected 0", busy_after); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h48; exp_b[1] = 8'h69; exp_b[2] = 8'h21;
    mem[8'h40] = 8'h48; mem[8'h41] = 8'h69; mem[8'h42] = 8'h21;
    sel = 3'd2; len = 6'd3; start = 1'b1;
    run_msg(3 * BYTE_CYC + 10, -1, -1);
    n_cmp++; if (rx_bytes.size() !== 3 || fstart.size() !== 3) begin
      n_fail++; $display("FAIL b2b_frames: got %0d expected 3", rx_bytes.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (rx_bytes[i] !== exp_b[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h expected %h", i, rx_bytes[i], exp_b[i]); end
        n_cmp++; if (faddr[i] !== 8'(8'h40 + i)) begin n_fail++; $display("FAIL b2b_addr%0d: got %h expected %h", i, faddr[i], 8'(8'h40 + i)); end
      end
      n_cmp++; if (fstart[1] - fstart[0] !== BYTE_CYC) begin n_fail++; $display("FAIL b2b_gap01: got %0d expected %0d", fstart[1] - fstart[0], BYTE_CYC); end
      n_cmp++; if (fstart[2] - fstart[1] !== BYTE_CYC) begin n_fail++; $display("FAIL b2b_gap12: got %0d expected %0d", fstart[2] - fstart[1], BYTE_CYC); end
    end
    n_cmp++; if (frame_err !== 0) begin n_fail++; $display("FAIL b2b_framing: got %0d expected 0", frame_err); end
    n_cmp++; if (done_cyc !== 3 * BYTE_CYC + 1) begin n_fail++; $display("FAIL b2b_done_cyc: got %0d expected %0d", done_cyc, 3 * BYTE_CYC + 1); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL b2b_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_zero_len();
    int zeros;
    sel = 3'd5; len = 6'd0; start = 1'b1;
    run_msg(10, -1, -1);
    zeros = 0;
    foreach (trace[i]) if (trace[i] !== 1'b1) zeros++;
    n_cmp++; if (done_cyc !== 1) begin n_fail++; $display("FAIL zero_done_cyc: got %0d expected 1", done_cyc); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_cnt: got %0d expected 1", done_cnt); end
    n_cmp++; if (zeros !== 0) begin n_fail++; $display("FAIL zero_tx_low_cycles: got %0d expected 0", zeros); end
    n_cmp++; if (mem_addr !== 8'h42) begin n_fail++; $display("FAIL zero_addr_hold: got %h expected 42", mem_addr); end
    n_cmp++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL zero_busy_after: got %b expected 0", busy_after); end
  endtask

  task automatic test_start_ignored();
    mem[8'h20] = 8'h3C;
    sel = 3'd1; len = 6'd1; start = 1'b1;
    run_msg(2 * BYTE_CYC + 10, 20, -1);
    n_cmp++; if (rx_bytes.size() !== 1) begin n_fail++; $display("FAIL ign_frames: got %0d expected 1", rx_bytes.size()); end
    else begin
      n_cmp++; if (rx_bytes[0] !== 8'h3C) begin n_fail++; $display("FAIL ign_byte: got %h expected 3c", rx_bytes[0]); end
      n_cmp++; if (faddr[0] !== 8'h20) begin n_fail++; $display("FAIL ign_addr: got %h expected 20", faddr[0]); end
    end
    n_cmp++; if (done_cyc !== BYTE_CYC + 1) begin n_fail++; $display("FAIL ign_done_cyc: got %0d expected %0d", done_cyc, BYTE_CYC + 1); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ign_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_reset_abort();
    mem[8'h40] = 8'hA5;
    sel = 3'd2; len = 6'd1; start = 1'b1;
    run_msg(60, -1, 20);
    n_cmp++; if (trace[19] !== 1'b0) begin n_fail++; $display("FAIL abort_tx_before: got %b expected 0", trace[19]); end
    n_cmp++; if (trace[20] !== 1'b1) begin n_fail++; $display("FAIL abort_tx_after: got %b expected 1", trace[20]); end
    n_cmp++; if (btrace[20] !== 1'b0) begin n_fail++; $display("FAIL abort_busy_after: got %b expected 0", btrace[20]); end
    n_cmp++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_done_cnt: got %0d expected 0", done_cnt); end
    n_cmp++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL abort_addr: got %h expected 00", mem_addr); end
  endtask

  task automatic test_clamp();
    logic [7:0] a;
    for (int i = 0; i < 32; i++) begin
      a = 8'(8'hE0 + i);
      mem[a] = a ^ 8'h5A;
    end
    sel = 3'd7; len = 6'd40; start = 1'b1;
    run_msg(32 * BYTE_CYC + 20, -1, -1);
    n_cmp++; if (rx_bytes.size() !== 32 || faddr.size() !== 32) begin
      n_fail++; $display("FAIL clamp_frames: got %0d expected 32", rx_bytes.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        a = 8'(8'hE0 + i);
        n_cmp++; if (rx_bytes[i] !== (a ^ 8'h5A)) begin n_fail++; $display("FAIL clamp_byte%0d: got %h expected %h", i, rx_bytes[i], a ^ 8'h5A); end
      end
      n_cmp++; if (faddr[31] !== 8'hFF) begin n_fail++; $display("FAIL clamp_last_addr: got %h expected ff", faddr[31]); end
    end
    n_cmp++; if (frame_err !== 0) begin n_fail++; $display("FAIL clamp_framing: got %0d expected 0", frame_err); end
    n_cmp++; if (done_cyc !== 32 * BYTE_CYC + 1) begin n_fail++; $display("FAIL clamp_done_cyc: got %0d expected %0d", done_cyc, 32 * BYTE_CYC + 1); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL clamp_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0; start = 1'b0; sel = '0; len = '0;
    n_cmp = 0; n_fail = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_zero_len();
    test_start_ignored();
    test_reset_abort();
    test_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
